// File: rtl/multi_channel_blinker.sv
// rtl/multi_channel_blinker.sv - shared-tick multi-channel blinker; optional PWM dimming via BLINKER_DIMMING_EN
module multi_channel_blinker #(
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int TICK_FREQUENCY_IN_HZ        = 8,
   parameter int CHANNELS                    = 4,
   parameter int PATTERN_WIDTH               = 8,
`ifdef BLINKER_DIMMING_EN
   parameter int DUTY_BITS                   = 4,
`endif
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2*CHANNELS-1:0]      mode,
   input  logic                       sync_restart,
   input  logic                       pattern_load,
   input  logic [SEL_W-1:0]           pattern_sel,
   input  logic [PATTERN_WIDTH-1:0]   pattern_data,
`ifdef BLINKER_DIMMING_EN
   input  logic [DUTY_BITS*CHANNELS-1:0] duty,
`endif
   output logic                       tick,
   output logic [CHANNELS-1:0]        blink
);

   localparam int DIV    = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int STEP_W = $clog2(PATTERN_WIDTH);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PATTERN_WIDTH - 1);

   logic [DIV_W-1:0]         divider;
   logic                     phase;
   logic [STEP_W-1:0]        step;
   logic [PATTERN_WIDTH-1:0] pattern [CHANNELS];
   logic                     wrap;
   logic [CHANNELS-1:0]      level;

   // The divider wrap, the tick pulse and the phase/step advance all happen on the same edge,
   // so blink picks up the new phase/step exactly one cycle after tick rises.
   assign wrap = (divider == DIV_LAST);

   // Shared timebase: divider, tick pulse, blink phase and pattern step; restart beats a coincident wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divider <= '0;
         tick    <= 1'b0;
         phase   <= 1'b0;
         step    <= '0;
      end else if (sync_restart) begin
         divider <= '0;
         tick    <= 1'b0;
         phase   <= 1'b0;
         step    <= '0;
      end else begin
         tick <= wrap;
         if (wrap) begin
            divider <= '0;
            phase   <= ~phase;
            step    <= (step == STEP_LAST) ? '0 : step + 1'b1;
         end else begin
            divider <= divider + 1'b1;
         end
      end
   end

   // Per-channel pattern registers; writes aimed past the last channel are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) pattern[i] <= '0;
      end else if (pattern_load && (int'(pattern_sel) < CHANNELS)) begin
         pattern[pattern_sel] <= pattern_data;
      end
   end

   // Unmodulated level per channel from its mode and the shared phase/step.
   always_comb begin
      level = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         case (mode[2*i +: 2])
            2'b00:   level[i] = 1'b0;
            2'b01:   level[i] = 1'b1;
            2'b10:   level[i] = phase;
            2'b11:   level[i] = pattern[i][step];
            default: level[i] = 1'b0;
         endcase
      end
   end

`ifdef BLINKER_DIMMING_EN
   logic [DUTY_BITS-1:0] pwm;

   // Free-running PWM ramp, independent of sync_restart so brightness never glitches on realign.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm <= '0;
      else     pwm <= pwm + 1'b1;
   end

   // Registered outputs gated by each channel's duty compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            blink[i] <= level[i] & (pwm < duty[i*DUTY_BITS +: DUTY_BITS]);
      end
   end
`else
   // Registered outputs carry the plain levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) blink <= '0;
      else     blink <= level;
   end
`endif

endmodule

// File: tb/tb_multi_channel_blinker.sv
// tb/tb_multi_channel_blinker.sv - self-checking bench for multi_channel_blinker
module tb_multi_channel_blinker;

   localparam int DIV = 10;
   localparam int CH  = 4;
   localparam int PW  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] mode;
   logic       sync_restart;
   logic       pattern_load;
   logic [1:0] pattern_sel;
   logic [7:0] pattern_data;
   logic       tick;
   logic [3:0] blink;

   logic [9:0] mode5;
   logic       load5;
   logic [2:0] sel5;
   logic [7:0] data5;
   logic       tick5;
   logic [4:0] blink5;

   int errors = 0;
   int checks = 0;

   // Reference model: k = clock edges since the last reset release or restart edge.
   int         k;
   logic [7:0] pat_m [CH];
   logic [3:0] exp_blink;
   logic       exp_tick;
   int         seq [8] = '{1, 1, 0, 0, 0, 1, 0, 1};

   multi_channel_blinker #(
      .BOARD_CLOCK_FREQUENCY_IN_HZ(100),
      .TICK_FREQUENCY_IN_HZ(10),
      .CHANNELS(CH),
      .PATTERN_WIDTH(PW)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .sync_restart(sync_restart),
      .pattern_load(pattern_load), .pattern_sel(pattern_sel), .pattern_data(pattern_data),
      .tick(tick), .blink(blink)
   );

   multi_channel_blinker #(
      .BOARD_CLOCK_FREQUENCY_IN_HZ(100),
      .TICK_FREQUENCY_IN_HZ(10),
      .CHANNELS(5),
      .PATTERN_WIDTH(PW)
   ) dut5 (
      .clk(clk), .rst(rst), .mode(mode5), .sync_restart(sync_restart),
      .pattern_load(load5), .pattern_sel(sel5), .pattern_data(data5),
      .tick(tick5), .blink(blink5)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output a channel set would show given registered state after kk edges since realign.
   function automatic logic [3:0] model_out(input logic [7:0] m, input int kk);
      int         ticks;
      logic [3:0] r;
      ticks = kk / DIV;
      r = '0;
      for (int i = 0; i < CH; i++) begin
         case (m[2*i +: 2])
            2'b01:   r[i] = 1'b1;
            2'b10:   r[i] = 1'(ticks % 2);
            2'b11:   r[i] = pat_m[i][ticks % PW];
            default: r[i] = 1'b0;
         endcase
      end
      return r;
   endfunction

   // One clock edge: predict, advance model, sample on the falling edge and compare.
   task automatic cycle();
      logic [3:0] nb;
      nb = model_out(mode, k);
      if (rst) begin
         k = 0;
         for (int i = 0; i < CH; i++) pat_m[i] = '0;
         exp_blink = '0;
         exp_tick  = 1'b0;
      end else begin
         if (pattern_load) pat_m[pattern_sel] = pattern_data;
         k = sync_restart ? 0 : k + 1;
         exp_tick  = !sync_restart && (k > 0) && (k % DIV == 0);
         exp_blink = nb;
      end
      @(posedge clk);
      @(negedge clk);
      check("tick", 32'(tick), 32'(exp_tick));
      check("blink", 32'(blink), 32'(exp_blink));
   endtask

   initial begin
      int n;
      rst = 1'b1; mode = 8'h55; sync_restart = 1'b0; pattern_load = 1'b0;
      pattern_sel = '0; pattern_data = '0;
      mode5 = 10'h3FF; load5 = 1'b0; sel5 = '0; data5 = '0;
      k = 0;
      for (int i = 0; i < CH; i++) pat_m[i] = '0;

      // 1: reset holds outputs low even with all channels on
      #2;
      check("reset_blink", 32'(blink), 32'h0);
      check("reset_tick", 32'(tick), 32'h0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) cycle();
      rst = 1'b0; mode = 8'h01;
      cycle();
      check("ch0_on_latency", 32'(blink[0]), 32'h1);

      // 2: ch1 square wave
      mode = 8'h09;
      for (int i = 0; i < 45; i++) cycle();

      // 3: pattern A3 on ch2 from a fresh alignment
      sync_restart = 1'b1; pattern_load = 1'b1; pattern_sel = 2'd2; pattern_data = 8'hA3;
      mode = 8'h39;
      cycle();
      sync_restart = 1'b0; pattern_load = 1'b0;
      for (int i = 0; i < 9 * DIV; i++) begin
         cycle();
         if (k % DIV == 5) check("pattern_seq", 32'(blink[2]), 32'(seq[(k / DIV) % 8]));
      end

      // 4: restart coincident with the divider wrap
      for (int i = 0; i < DIV && (k % DIV) != DIV - 1; i++) cycle();
      sync_restart = 1'b1;
      cycle();
      sync_restart = 1'b0;
      check("restart_no_tick", 32'(tick), 32'h0);
      n = 0;
      for (int i = 1; i <= 2 * DIV; i++) begin
         cycle();
         if (i == 2) begin
            check("restart_phase0", 32'(blink[1]), 32'h0);
            check("restart_step0", 32'(blink[2]), 32'h1);
         end
         if (tick) begin
            n = i;
            break;
         end
      end
      check("restart_tick_gap", 32'(n), 32'(DIV));

      // 5: out-of-range select on a five-channel instance
      load5 = 1'b1; sel5 = 3'd5; data5 = 8'hFF;
      cycle();
      sel5 = 3'd7;
      cycle();
      load5 = 1'b0;
      cycle();
      cycle();
      check("sel_out_of_range", 32'(blink5), 32'h0);
      load5 = 1'b1; sel5 = 3'd4;
      cycle();
      load5 = 1'b0;
      cycle();
      check("sel_last_channel", 32'(blink5), 32'h10);

      // Randomized modes, loads and restarts
      for (int i = 0; i < 400; i++) begin
         mode         = 8'($urandom);
         pattern_load = ($urandom % 4) == 0;
         pattern_sel  = 2'($urandom);
         pattern_data = 8'($urandom);
         sync_restart = ($urandom % 40) == 0;
         cycle();
      end
      pattern_load = 1'b0; sync_restart = 1'b0;

      // 6: asynchronous reset in the middle of a pattern
      pattern_load = 1'b1; pattern_sel = 2'd0; pattern_data = 8'hFF; mode = 8'hFF;
      cycle();
      pattern_load = 1'b0;
      for (int i = 0; i < 13; i++) cycle();
      check("pre_reset_active", 32'(blink[0]), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_blink", 32'(blink), 32'h0);
      check("async_reset_tick", 32'(tick), 32'h0);
      k = 0;
      for (int i = 0; i < CH; i++) pat_m[i] = '0;
      @(negedge clk);
      cycle();
      rst = 1'b0;
      pattern_load = 1'b1; pattern_sel = 2'd1; pattern_data = 8'h01;
      cycle();
      pattern_load = 1'b0;
      cycle();
      check("post_reset_step0", 32'(blink[1]), 32'h1);
      for (int i = 0; i < 3 * DIV; i++) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
